// File: rtl/slip_divider.sv
// Sequential restoring divider: one quotient bit per clock via a (WIDTH+1)-bit trial subtraction.
// Define SLIP_DIVIDER_SIGNED_EN for two's-complement operands (adds one FIX cycle of latency).
module slip_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dz_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

`ifdef SLIP_DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic             dz_flag_q;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] r_d, q_d;
  logic [WIDTH-1:0] dvd_mag_d, dsr_mag_d;
`ifdef SLIP_DIVIDER_SIGNED_EN
  logic             dvd_neg_q, sign_diff_q;
`endif

  // Operand magnitudes at load and one restoring-division step
  always_comb begin
`ifdef SLIP_DIVIDER_SIGNED_EN
    dvd_mag_d = dividend_i[WIDTH-1] ? (~dividend_i + ONE) : dividend_i;
    dsr_mag_d = divisor_i[WIDTH-1]  ? (~divisor_i + ONE)  : divisor_i;
`else
    dvd_mag_d = dividend_i;
    dsr_mag_d = divisor_i;
`endif
    trial_d = {r_q, q_q[WIDTH-1]} - {1'b0, d_q};
    if (!trial_d[WIDTH]) begin
      r_d = trial_d[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      // Restore: the shifted partial remainder is below D, so it fits in WIDTH bits
      r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      dz_flag_q   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      dz_o        <= 1'b0;
`ifdef SLIP_DIVIDER_SIGNED_EN
      dvd_neg_q   <= 1'b0;
      sign_diff_q <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            r_q         <= '0;
            q_q         <= dvd_mag_d;
            d_q         <= dsr_mag_d;
            cnt_q       <= CNT_LOAD;
            dz_flag_q   <= (divisor_i == '0);
            quotient_o  <= '0;
            remainder_o <= '0;
            dz_o        <= 1'b0;
            busy_o      <= 1'b1;
            state_q     <= RUN;
`ifdef SLIP_DIVIDER_SIGNED_EN
            dvd_neg_q   <= dividend_i[WIDTH-1];
            sign_diff_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
`endif
          end else begin
            busy_o <= 1'b0;
          end
        end
        RUN: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
`ifdef SLIP_DIVIDER_SIGNED_EN
            state_q <= FIX;
`else
            quotient_o  <= q_d;
            remainder_o <= r_d;
            dz_o        <= dz_flag_q;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
            state_q     <= IDLE;
`endif
          end else begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
`ifdef SLIP_DIVIDER_SIGNED_EN
        FIX: begin
          // Zero divisor keeps the all-ones quotient; remainder sign follows the dividend
          if (dz_flag_q) begin
            quotient_o <= '1;
          end else if (sign_diff_q) begin
            quotient_o <= ~q_q + ONE;
          end else begin
            quotient_o <= q_q;
          end
          remainder_o <= dvd_neg_q ? (~r_q + ONE) : r_q;
          dz_o        <= dz_flag_q;
          done_o      <= 1'b1;
          busy_o      <= 1'b0;
          state_q     <= IDLE;
        end
`endif
        default: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
